// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bus bundle for if_prefetch_queue: redirect input, imem port and decode-facing queue head.
// master = fetch unit, slave = surrounding pipeline/memory.
interface if_prefetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_data, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_data, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch front end: owns fetch PC, issues imem reads, queues {instr, pc} ahead of IF/ID.
// Optional feature macro PREFETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    if_prefetch_queue_if.master  fetchBus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]          stat_fetched,
    output logic [15:0]          stat_flushed
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [31:0]       qInstr [DEPTH];
    logic [31:0]       qPc    [DEPTH];

    logic [31:0]       fetchPc, fetchPcNext;
    logic [31:0]       inflightPc, inflightPcNext;
    logic              inflight, inflightNext;
    logic [PTR_W-1:0]  headPtr, headNext;
    logic [PTR_W-1:0]  tailPtr, tailNext;
    logic [CNT_W-1:0]  count, countNext;

    logic              outValid;
    logic              issue;
    logic              doPush;
    logic              doPop;
    logic [OCC_W-1:0]  occupancy;

    // Queued plus in-flight words bound the next issue so a return always has a slot.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight);
    assign issue     = !rst && !fetchBus.redirect_valid && (occupancy < OCC_W'(DEPTH));
    assign outValid  = !rst && (count != '0);

    assign fetchBus.imem_req  = issue;
    assign fetchBus.imem_addr = fetchPc;
    assign fetchBus.out_valid = outValid;
    assign fetchBus.out_instr = outValid ? qInstr[headPtr] : 32'h0;
    assign fetchBus.out_pc    = outValid ? qPc[headPtr]    : 32'h0;

    // Next-state: redirect wins over push, pop and issue.
    always_comb begin
        fetchPcNext    = fetchPc;
        inflightNext   = inflight;
        inflightPcNext = inflightPc;
        headNext       = headPtr;
        tailNext       = tailPtr;
        countNext      = count;
        doPush         = 1'b0;
        doPop          = 1'b0;

        if (fetchBus.redirect_valid) begin
            countNext    = '0;
            headNext     = tailPtr;
            inflightNext = 1'b0;
            fetchPcNext  = fetchBus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            doPush = inflight;
            doPop  = outValid && fetchBus.out_ready;
            if (doPush) begin
                tailNext = tailPtr + PTR_W'(1);
            end
            if (doPop) begin
                headNext = headPtr + PTR_W'(1);
            end
            countNext = count + CNT_W'(doPush) - CNT_W'(doPop);
            if (issue) begin
                inflightNext   = 1'b1;
                inflightPcNext = fetchPc;
                fetchPcNext    = fetchPc + 32'd4;
            end else if (doPush) begin
                inflightNext = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= 32'h0;
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
        end else begin
            fetchPc    <= fetchPcNext;
            inflight   <= inflightNext;
            inflightPc <= inflightPcNext;
            headPtr    <= headNext;
            tailPtr    <= tailNext;
            count      <= countNext;
        end
    end

    // Queue storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            qInstr[tailPtr] <= fetchBus.imem_data;
            qPc[tailPtr]    <= inflightPc;
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= 32'h0;
            stat_flushed <= 16'h0;
        end else begin
            if (doPop) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (fetchBus.redirect_valid && ((count != '0) || inflight)) begin
                stat_flushed <= stat_flushed + 16'd1;
            end
        end
    end
`endif

endmodule
